uio_axi_rx_pack: RTL and testbench



---
 rtl/uio_axi_pkg.sv | 7 +
 rtl/uio_rx_fifo.sv | 33 +++
 rtl/uio_axi_rx_pack.sv | 90 +++++++++
 tb/tb_uio_axi_rx_pack.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_axi_pkg.sv
// uio_axi_pkg: shared widths and pack FSM state for the UIO/AXI link converters
package uio_axi_pkg;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_KEEP_W = 8;
  localparam int UIO_W = 128;
  typedef enum logic {LO, HI} pack_st_e;
endpackage

// File: rtl/uio_rx_fifo.sv
// uio_rx_fifo: single-clock FIFO of packed UIO words; callers gate push/pop against full/empty
module uio_rx_fifo import uio_axi_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [UIO_W-1:0] wdata,
  input  logic             pop,
  output logic [UIO_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [UIO_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign rdata = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/uio_axi_rx_pack.sv
// uio_axi_rx_pack: packs 64-bit Aurora RX beats into 128-bit UIO response words (stats: UIO_AXI_RX_STATS_EN)
module uio_axi_rx_pack import uio_axi_pkg::*; #(
  parameter int UIO_PORTS_WIDTH = 128,
  parameter int FIFO_DEPTH = 16
`ifdef UIO_AXI_RX_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXI_KEEP_W-1:0]      i_m_axi_rx_tkeep,
  input  logic [AXI_DATA_W-1:0]      i_m_axi_rx_tdata,
  input  logic                       i_m_axi_rx_tlast,
  input  logic                       i_m_axi_rx_tvalid,
  input  logic                       i_stat_chan_up,
  output logic                       uio_rs_vld,
  output logic [UIO_PORTS_WIDTH-1:0] uio_rs_data,
  input  logic                       uio_rs_afull,
  output logic                       o_overflow,
`ifdef UIO_AXI_RX_STATS_EN
  output logic [CNT_W-1:0]           o_word_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt,
`endif
  output logic                       o_keep_err
);
  if (UIO_PORTS_WIDTH != 2 * AXI_DATA_W) begin : g_bad_width
    $error("uio_axi_rx_pack: UIO_PORTS_WIDTH must be 128");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uio_axi_rx_pack: FIFO_DEPTH must be a power of two >= 4");
  end
  pack_st_e st, st_nx;
  logic [AXI_DATA_W-1:0] masked, held;
  logic [UIO_W-1:0] word, head;
  logic beat, push, pop, accept, full, empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic unused;
  assign unused = ^fifo_count;
  for (genvar i = 0; i < AXI_KEEP_W; i++) begin : g_mask
    assign masked[i*8 +: 8] = i_m_axi_rx_tkeep[i] ? i_m_axi_rx_tdata[i*8 +: 8] : 8'h0;
  end
  assign beat = i_m_axi_rx_tvalid & i_stat_chan_up;
  assign push = beat & (st == HI | i_m_axi_rx_tlast);
  assign word = st == HI ? {masked, held} : {{AXI_DATA_W{1'b0}}, masked};
  assign pop = !empty & !uio_rs_afull;
  // a full FIFO still takes the word when the head leaves in the same cycle
  assign accept = push & (!full | pop);
  always_comb
    st_nx = !i_stat_chan_up ? LO : !i_m_axi_rx_tvalid ? st : (st == LO && !i_m_axi_rx_tlast) ? HI : LO;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= LO;
    else st <= st_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) held <= '0;
    else if (!i_stat_chan_up) held <= '0;
    else if (beat && st == LO && !i_m_axi_rx_tlast) held <= masked;
  uio_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .wdata(word),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      uio_rs_vld <= 1'b0;
      uio_rs_data <= '0;
      o_overflow <= 1'b0;
      o_keep_err <= 1'b0;
    end else begin
      uio_rs_vld <= pop;
      if (pop) uio_rs_data <= head;
      o_overflow <= o_overflow | (push & !accept);
      o_keep_err <= o_keep_err | (beat & !i_m_axi_rx_tlast & (i_m_axi_rx_tkeep != 8'hFF));
    end
`ifdef UIO_AXI_RX_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      o_word_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (accept && !(&o_word_cnt)) o_word_cnt <= o_word_cnt + 1'b1;
      if (push && !accept && !(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_uio_axi_rx_pack.sv
// tb_uio_axi_rx_pack: randomized and directed checks of uio_axi_rx_pack against a queue-based model
module tb_uio_axi_rx_pack;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1;
  logic [7:0] tkeep = 8'hFF;
  logic [63:0] tdata = '0;
  logic tlast = 0, tvalid = 0, up = 0, afull = 0;
  logic vld, ovf, kerr;
  logic [127:0] data;
`ifdef UIO_AXI_RX_STATS_EN
  logic [31:0] wcnt, dcnt;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  uio_axi_rx_pack #(.UIO_PORTS_WIDTH(128), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_m_axi_rx_tkeep (tkeep),
    .i_m_axi_rx_tdata (tdata),
    .i_m_axi_rx_tlast (tlast),
    .i_m_axi_rx_tvalid(tvalid),
    .i_stat_chan_up   (up),
    .uio_rs_vld       (vld),
    .uio_rs_data      (data),
    .uio_rs_afull     (afull),
    .o_overflow       (ovf),
`ifdef UIO_AXI_RX_STATS_EN
    .o_word_cnt       (wcnt),
    .o_drop_cnt       (dcnt),
`endif
    .o_keep_err       (kerr)
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [63:0] mask(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  logic [127:0] q[$];
  bit have;
  logic [63:0] held;
  logic exp_vld;
  logic [127:0] exp_data;
  bit exp_ovf, exp_kerr;
  int exp_acc, exp_drop;
  always @(posedge clk or posedge reset) begin : model
    bit p, pw;
    logic [127:0] w;
    logic [63:0] m;
    if (reset) begin
      q.delete();
      have = 0; held = '0; exp_vld = 0; exp_data = '0;
      exp_ovf = 0; exp_kerr = 0; exp_acc = 0; exp_drop = 0;
    end else begin
      pw = 0;
      w = '0;
      if (tvalid && up) begin
        m = mask(tdata, tkeep);
        if (!tlast && tkeep != 8'hFF) exp_kerr = 1;
        if (have) begin w = {m, held}; pw = 1; have = 0; end
        else if (tlast) begin w = {64'h0, m}; pw = 1; end
        else begin held = m; have = 1; end
      end
      if (!up) have = 0;
      p = q.size() > 0 && !afull;
      exp_vld = p;
      if (p) exp_data = q.pop_front();
      if (pw) begin
        if (q.size() < DEPTH) begin q.push_back(w); exp_acc++; end
        else begin exp_ovf = 1; exp_drop++; end
      end
    end
  end

  logic [127:0] got[$];
  int got_cyc[$];
  int ncnt = 0;
  always @(posedge clk) ncnt <= ncnt + 1;
  always @(negedge clk) if (!reset) begin
    chk("vld", vld, exp_vld);
    chk("data", data, exp_data);
    chk("overflow", ovf, exp_ovf);
    chk("keep_err", kerr, exp_kerr);
`ifdef UIO_AXI_RX_STATS_EN
    chk("word_cnt", wcnt, exp_acc);
    chk("drop_cnt", dcnt, exp_drop);
`endif
    if (vld) begin got.push_back(data); got_cyc.push_back(ncnt); end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    tdata = d; tkeep = k; tlast = l; tvalid = 1;
    @(posedge clk); #1;
    tvalid = 0; tlast = 0;
  endtask
  task automatic words(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      beat(base + 64'(2*i), 8'hFF, 0);
      beat(base + 64'(2*i+1), 8'hFF, 1);
    end
  endtask
  task automatic reset_dut();
    reset = 1; idle(2); reset = 0; idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b2, n0, extra;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", vld, 0);
    chk("rst_data", data, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_keep_err", kerr, 0);
    reset = 0; up = 1;
    idle(2);

    got.delete(); got_cyc.delete();
    beat(64'h1, 8'hFF, 0);
    b2 = ncnt;
    beat(64'h2, 8'hFF, 0);
    beat(64'h3, 8'hFF, 0);
    beat(64'h4, 8'hFF, 1);
    idle(6);
    chk("pack_count", got.size(), 2);
    chk("pack_w0", got[0], {64'h2, 64'h1});
    chk("pack_w1", got[1], {64'h4, 64'h3});
    chk("pack_latency", got_cyc[0] - b2, 2);

    got.delete();
    beat(64'hAAAA_0000_0000_000A, 8'hFF, 0);
    beat(64'hBBBB_0000_0000_000B, 8'hFF, 0);
    beat(64'hCCCC_0000_0000_000C, 8'hFF, 1);
    idle(6);
    chk("odd_count", got.size(), 2);
    chk("odd_w0", got[0], {64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});
    chk("odd_w1", got[1], {64'h0, 64'hCCCC_0000_0000_000C});

    got.delete();
    beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1);
    idle(5);
    chk("keep_last_word", got[0], 128'h0000_0000_FFFF_FFFF);
    chk("keep_last_noerr", kerr, 0);
    beat(64'h1122_3344_5566_7788, 8'h7F, 0);
    beat(64'h99, 8'hFF, 1);
    idle(5);
    chk("keep_err_set", kerr, 1);
    chk("keep_partial_word", got[1], {64'h99, 64'h0022_3344_5566_7788});

    afull = 1;
    got.delete(); got_cyc.delete();
    words(5, 64'h100);
    idle(5);
    chk("bp_hold", got.size(), 0);
    afull = 0;
    idle(8);
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_order", got[i], {64'h100 + 64'(2*i+1), 64'h100 + 64'(2*i)});
    chk("bp_back2back", got_cyc[4] - got_cyc[0], 4);

    afull = 1;
    words(6, 64'h200);
    got.delete();
    afull = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(negedge clk); ok = vld; end
    @(posedge clk); #1;
    chk("mid_first_vld", ok, 1);
    afull = 1;
    n0 = got.size();
    idle(10);
    extra = got.size() - n0;
    chk("mid_extra_le1", extra <= 1, 1);
    afull = 0;
    idle(10);
    chk("mid_count", got.size(), 6);
    chk("mid_last", got[5], {64'h20B, 64'h20A});

    reset_dut();
    afull = 1;
    got.delete();
    words(DEPTH + 2, 64'h300);
    idle(2);
    chk("ovf_set", ovf, 1);
`ifdef UIO_AXI_RX_STATS_EN
    chk("ovf_word_cnt", wcnt, DEPTH);
    chk("ovf_drop_cnt", dcnt, 2);
`endif
    afull = 0;
    idle(DEPTH + 5);
    chk("ovf_delivered", got.size(), DEPTH);
    chk("ovf_last", got[DEPTH-1], {64'h300 + 64'(2*DEPTH-1), 64'h300 + 64'(2*DEPTH-2)});

    got.delete();
    beat(64'hA, 8'hFF, 0);
    up = 0;
    beat(64'hEE, 8'hFF, 1);
    up = 1;
    beat(64'hB, 8'hFF, 0);
    beat(64'hC, 8'hFF, 1);
    idle(6);
    chk("chan_count", got.size(), 1);
    chk("chan_word", got[0], {64'hC, 64'hB});

    afull = 1;
    words(3, 64'h500);
    got.delete();
    afull = 0;
    idle(1);
    chk("pre_rst_vld", vld, 1);
    reset = 1;
    #1;
    chk("async_rst_vld", vld, 0);
    chk("async_rst_data", data, 0);
    idle(2);
    reset = 0;
    idle(20);
    chk("post_rst_none", got.size(), 0);

    for (int c = 0; c < 3000; c++) begin
      up = $urandom_range(0, 19) != 0;
      afull = $urandom_range(0, 3) == 0;
      tvalid = $urandom_range(0, 2) != 0;
      tdata = {$urandom, $urandom};
      tkeep = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'hFF;
      tlast = $urandom_range(0, 2) == 0;
      @(posedge clk); #1;
    end
    tvalid = 0; tlast = 0; afull = 0; up = 1;
    idle(40);
    chk("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
